// File: rtl/tracker_pkg.sv
// Shared types, widths and saturating arithmetic for the enemy tracker.
// TRACKER_PREDICT_EN (optional) enables one-cycle lead prediction in the slots.
package tracker_pkg;

  localparam int unsigned POS_W  = 8;
  localparam int unsigned VEL_W  = 5;
  localparam int unsigned DIFF_W = POS_W + 1;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    ST_UNSEEN  = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_TRACK   = 3'd2,
    ST_COAST   = 3'd3,
    ST_LOST    = 3'd4,
    ST_DEAD    = 3'd5
  } track_state_e;

  localparam logic signed [DIFF_W-1:0] SAT5_MAX = 9'sd15;
  localparam logic signed [DIFF_W-1:0] SAT5_MIN = -9'sd16;
  localparam logic signed [DIFF_W-1:0] SAT8_MAX = 9'sd127;
  localparam logic signed [DIFF_W-1:0] SAT8_MIN = -9'sd128;

  function automatic logic signed [VEL_W-1:0] sat5(input logic signed [DIFF_W-1:0] v);
    logic signed [VEL_W-1:0] r;
    if (v > SAT5_MAX)      r = 5'sd15;
    else if (v < SAT5_MIN) r = -5'sd16;
    else                   r = v[VEL_W-1:0];
    return r;
  endfunction

  function automatic logic signed [POS_W-1:0] sat8(input logic signed [DIFF_W-1:0] v);
    logic signed [POS_W-1:0] r;
    if (v > SAT8_MAX)      r = 8'sd127;
    else if (v < SAT8_MIN) r = -8'sd128;
    else                   r = v[POS_W-1:0];
    return r;
  endfunction

  // Velocity estimate from a new sample and the previous position.
  function automatic logic signed [VEL_W-1:0] vel_est(input logic signed [POS_W-1:0] cur,
                                                      input logic signed [POS_W-1:0] prev);
    logic signed [DIFF_W-1:0] d;
    d = {cur[POS_W-1], cur} - {prev[POS_W-1], prev};
    return sat5(d);
  endfunction

  // Position advanced by one cycle of velocity, clamped rather than wrapped.
  function automatic logic signed [POS_W-1:0] pos_adv(input logic signed [POS_W-1:0] p,
                                                      input logic signed [VEL_W-1:0] v);
    logic signed [DIFF_W-1:0] s;
    s = {p[POS_W-1], p} + {{(DIFF_W-VEL_W){v[VEL_W-1]}}, v};
    return sat8(s);
  endfunction

endpackage

// File: rtl/enemy_track_slot.sv
// One enemy track: acquire/track/coast state machine with pos, vel and coast registers.
// TRACKER_PREDICT_EN: output leads by one cycle and COAST dead-reckons pos.
module enemy_track_slot
  import tracker_pkg::*;
#(
  parameter int unsigned COAST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [POS_W-1:0] x_i,
  input  logic signed [POS_W-1:0] y_i,
  input  logic                    cloaked_i,
  input  logic                    destroyed_i,
  output logic signed [POS_W-1:0] trk_x_o,
  output logic signed [POS_W-1:0] trk_y_o,
  output logic signed [VEL_W-1:0] trk_vx_o,
  output logic signed [VEL_W-1:0] trk_vy_o,
  output logic                    trk_valid_o,
  output logic [2:0]              trk_state_o,
  output logic [CNT_W-1:0]        trk_coast_cnt_o
);

  track_state_e            state_q, state_d;
  logic signed [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [CNT_W-1:0]        coast_q, coast_d;
  logic signed [POS_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic signed [POS_W-1:0] coast_x, coast_y;
  logic                    valid_q, valid_d;

  // Where a cloaked track's position goes for the next cycle.
`ifdef TRACKER_PREDICT_EN
  assign coast_x = pos_adv(pos_x_q, vel_x_q);
  assign coast_y = pos_adv(pos_y_q, vel_y_q);
`else
  assign coast_x = pos_x_q;
  assign coast_y = pos_y_q;
`endif

  // Next-state logic; destroyed overrides cloak, cloak overrides visibility.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    coast_d = coast_q;
    if (destroyed_i) begin
      state_d = ST_DEAD;
      vel_x_d = '0;
      vel_y_d = '0;
      coast_d = '0;
    end else begin
      unique case (state_q)
        ST_UNSEEN, ST_LOST: begin
          if (!cloaked_i) begin
            state_d = ST_ACQUIRE;
            pos_x_d = x_i;
            pos_y_d = y_i;
            vel_x_d = '0;
            vel_y_d = '0;
          end
        end
        ST_ACQUIRE: begin
          if (cloaked_i) begin
            state_d = ST_LOST;
            vel_x_d = '0;
            vel_y_d = '0;
          end else begin
            state_d = ST_TRACK;
            vel_x_d = vel_est(x_i, pos_x_q);
            vel_y_d = vel_est(y_i, pos_y_q);
            pos_x_d = x_i;
            pos_y_d = y_i;
          end
        end
        ST_TRACK: begin
          if (cloaked_i) begin
            state_d = ST_COAST;
            coast_d = CNT_W'(1);
            pos_x_d = coast_x;
            pos_y_d = coast_y;
          end else begin
            vel_x_d = vel_est(x_i, pos_x_q);
            vel_y_d = vel_est(y_i, pos_y_q);
            pos_x_d = x_i;
            pos_y_d = y_i;
          end
        end
        ST_COAST: begin
          if (cloaked_i) begin
            if (coast_q >= CNT_W'(COAST_MAX)) begin
              state_d = ST_LOST;
              vel_x_d = '0;
              vel_y_d = '0;
              coast_d = '0;
            end else begin
              coast_d = coast_q + CNT_W'(1);
              pos_x_d = coast_x;
              pos_y_d = coast_y;
            end
          end else begin
            // Frozen pre-cloak inputs are stale, so restart acquisition.
            state_d = ST_ACQUIRE;
            pos_x_d = x_i;
            pos_y_d = y_i;
            vel_x_d = '0;
            vel_y_d = '0;
            coast_d = '0;
          end
        end
        ST_DEAD: begin
          vel_x_d = '0;
          vel_y_d = '0;
        end
        default: begin
          state_d = ST_UNSEEN;
          pos_x_d = '0;
          pos_y_d = '0;
          vel_x_d = '0;
          vel_y_d = '0;
          coast_d = '0;
        end
      endcase
    end
  end

  // Published target, computed from next-state so outputs stay registered.
  always_comb begin
`ifdef TRACKER_PREDICT_EN
    out_x_d = pos_adv(pos_x_d, vel_x_d);
    out_y_d = pos_adv(pos_y_d, vel_y_d);
`else
    out_x_d = pos_x_d;
    out_y_d = pos_y_d;
`endif
    valid_d = (state_d == ST_TRACK) || (state_d == ST_COAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UNSEEN;
      pos_x_q <= '0;
      pos_y_q <= '0;
      vel_x_q <= '0;
      vel_y_q <= '0;
      coast_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
      coast_q <= coast_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      valid_q <= valid_d;
    end
  end

  assign trk_x_o         = out_x_q;
  assign trk_y_o         = out_y_q;
  assign trk_vx_o        = vel_x_q;
  assign trk_vy_o        = vel_y_q;
  assign trk_valid_o     = valid_q;
  assign trk_state_o     = state_q;
  assign trk_coast_cnt_o = coast_q;

endmodule

// File: rtl/enemy_tracker.sv
// Per-enemy tracking stage: one independent enemy_track_slot per ship.
// TRACKER_PREDICT_EN selects predicted (lead) target positions inside each slot.
module enemy_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned NUM_SHIPS = 3,
  parameter int unsigned COAST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [POS_W-1:0] enemy_x_p       [NUM_SHIPS],
  input  logic signed [POS_W-1:0] enemy_y_p       [NUM_SHIPS],
  input  logic [NUM_SHIPS-1:0]    enemy_cloaked,
  input  logic [NUM_SHIPS-1:0]    enemy_destroyed,
  output logic signed [POS_W-1:0] trk_x           [NUM_SHIPS],
  output logic signed [POS_W-1:0] trk_y           [NUM_SHIPS],
  output logic signed [VEL_W-1:0] trk_vx          [NUM_SHIPS],
  output logic signed [VEL_W-1:0] trk_vy          [NUM_SHIPS],
  output logic [NUM_SHIPS-1:0]    trk_valid,
  output logic [2:0]              trk_state       [NUM_SHIPS],
  output logic [CNT_W-1:0]        trk_coast_cnt   [NUM_SHIPS]
);

  for (genvar g = 0; g < NUM_SHIPS; g++) begin : g_slot
    enemy_track_slot #(
      .COAST_MAX(COAST_MAX)
    ) u_slot (
      .clk             (clk),
      .reset           (reset),
      .x_i             (enemy_x_p[g]),
      .y_i             (enemy_y_p[g]),
      .cloaked_i       (enemy_cloaked[g]),
      .destroyed_i     (enemy_destroyed[g]),
      .trk_x_o         (trk_x[g]),
      .trk_y_o         (trk_y[g]),
      .trk_vx_o        (trk_vx[g]),
      .trk_vy_o        (trk_vy[g]),
      .trk_valid_o     (trk_valid[g]),
      .trk_state_o     (trk_state[g]),
      .trk_coast_cnt_o (trk_coast_cnt[g])
    );
  end

endmodule

// File: tb/tb_enemy_tracker.sv
// Directed bench for enemy_tracker; expectations follow TRACKER_PREDICT_EN when defined.
module tb_enemy_tracker;

  localparam int unsigned N = 3;

`ifdef TRACKER_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic signed [7:0] ex [N];
  logic signed [7:0] ey [N];
  logic [N-1:0]      cloaked;
  logic [N-1:0]      destroyed;
  logic signed [7:0] tx [N];
  logic signed [7:0] ty [N];
  logic signed [4:0] vx [N];
  logic signed [4:0] vy [N];
  logic [N-1:0]      valid;
  logic [2:0]        st [N];
  logic [2:0]        cc [N];

  int checks = 0;
  int errors = 0;

  enemy_tracker #(.NUM_SHIPS(N), .COAST_MAX(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .enemy_x_p       (ex),
    .enemy_y_p       (ey),
    .enemy_cloaked   (cloaked),
    .enemy_destroyed (destroyed),
    .trk_x           (tx),
    .trk_y           (ty),
    .trk_vx          (vx),
    .trk_vy          (vy),
    .trk_valid       (valid),
    .trk_state       (st),
    .trk_coast_cnt   (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int s, input int x, input int y);
    ex[s] = 8'(x);
    ey[s] = 8'(y);
  endtask

  // Full check of one slot's outputs.
  task automatic slot(input string tag, input int s, input int e_st, input int e_x, input int e_y,
                      input int e_vx, input int e_vy, input int e_val, input int e_cc);
    chk({tag, ".state"}, int'(st[s]), e_st);
    chk({tag, ".x"},     int'(tx[s]), e_x);
    chk({tag, ".y"},     int'(ty[s]), e_y);
    chk({tag, ".vx"},    int'(vx[s]), e_vx);
    chk({tag, ".vy"},    int'(vy[s]), e_vy);
    chk({tag, ".valid"}, int'(valid[s]), e_val);
    chk({tag, ".coast"}, int'(cc[s]), e_cc);
  endtask

  initial begin
    reset = 1'b1;
    cloaked = '0;
    destroyed = '0;
    for (int i = 0; i < int'(N); i++) setp(i, 0, 0);
    step();
    step();
    for (int i = 0; i < int'(N); i++) slot("reset", i, 0, 0, 0, 0, 0, 0, 0);

    // Slot 0 acquires; slots 1 and 2 stay cloaked and must stay UNSEEN.
    reset = 1'b0;
    cloaked = 3'b110;
    setp(0, 10, -5);
    step();
    slot("acq", 0, 1, 10, -5, 0, 0, 0, 0);
    chk("idle1.state", int'(st[1]), 0);
    setp(0, 13, -7);
    step();
    slot("trk", 0, 2, PRED ? 16 : 13, PRED ? -9 : -7, 3, -2, 1, 0);

    // Coast for exactly 4 cycles, then lost.
    cloaked[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      slot($sformatf("coast%0d", k), 0, 3, PRED ? 13 + 3*(k+1) : 13,
           PRED ? -7 - 2*(k+1) : -7, 3, -2, 1, k);
    end
    step();
    slot("lost", 0, 4, PRED ? 25 : 13, PRED ? -15 : -7, 0, 0, 0, 0);

    // Re-acquire, coast briefly, uncloak mid-coast.
    cloaked[0] = 1'b0;
    setp(0, 20, 20);
    step();
    chk("reacq.state", int'(st[0]), 1);
    setp(0, 22, 21);
    step();
    chk("retrk.vx", int'(vx[0]), 2);
    cloaked[0] = 1'b1;
    step();
    step();
    chk("coast2.cnt", int'(cc[0]), 2);
    cloaked[0] = 1'b0;
    setp(0, 0, 0);
    step();
    slot("uncloak", 0, 1, 0, 0, 0, 0, 0, 0);
    setp(0, 1, 1);
    step();
    slot("uncloak_trk", 0, 2, PRED ? 2 : 1, PRED ? 2 : 1, 1, 1, 1, 0);

    // Saturation: large jumps clamp velocity and position.
    setp(0, -128, -128);
    step();
    slot("sat_neg", 0, 2, -128, -128, -16, -16, 1, 0);
    setp(0, 127, 127);
    step();
    slot("sat_pos", 0, 2, 127, 127, 15, 15, 1, 0);
    cloaked[0] = 1'b1;
    step();
    slot("sat_coast", 0, 3, 127, 127, 15, 15, 1, 1);

    // Destroyed together with cloak from TRACK resolves to DEAD.
    cloaked[0] = 1'b0;
    setp(0, 127, 127);
    step();
    chk("pre_dead.state", int'(st[0]), 1);
    setp(0, 120, 127);
    step();
    slot("pre_dead_trk", 0, 2, PRED ? 113 : 120, 127, -7, 0, 1, 0);
    cloaked[0] = 1'b1;
    destroyed[0] = 1'b1;
    step();
    slot("dead", 0, 5, 120, 127, 0, 0, 0, 0);
    cloaked[0] = 1'b0;
    destroyed[0] = 1'b0;
    setp(0, 50, 50);
    step();
    slot("dead_sticky", 0, 5, 120, 127, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    slot("dead_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Three slots with simultaneous, different events.
    cloaked = '0;
    setp(0, 1, 2);
    setp(1, -10, 10);
    setp(2, 40, -40);
    step();
    for (int i = 0; i < int'(N); i++) chk($sformatf("multi_acq%0d.state", i), int'(st[i]), 1);
    setp(0, 3, 3);
    setp(1, -14, 13);
    setp(2, 41, -40);
    step();
    slot("m_trk0", 0, 2, PRED ? 5 : 3, PRED ? 4 : 3, 2, 1, 1, 0);
    slot("m_trk1", 1, 2, PRED ? -18 : -14, PRED ? 16 : 13, -4, 3, 1, 0);
    slot("m_trk2", 2, 2, PRED ? 42 : 41, -40, 1, 0, 1, 0);
    setp(0, 5, 4);
    cloaked[1] = 1'b1;
    destroyed[2] = 1'b1;
    step();
    slot("m_ev0", 0, 2, PRED ? 7 : 5, PRED ? 5 : 4, 2, 1, 1, 0);
    slot("m_ev1", 1, 3, PRED ? -22 : -14, PRED ? 19 : 13, -4, 3, 1, 1);
    slot("m_ev2", 2, 5, 41, -40, 0, 0, 0, 0);
    setp(0, 8, 4);
    step();
    slot("m_nx0", 0, 2, PRED ? 11 : 8, 4, 3, 0, 1, 0);
    slot("m_nx1", 1, 3, PRED ? -26 : -14, PRED ? 22 : 13, -4, 3, 1, 2);
    slot("m_nx2", 2, 5, 41, -40, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_tracker.md
# enemy_tracker

Per-enemy tracking stage sitting directly upstream of the ship decision logic. It registers the raw enemy position inputs and estimates each enemy's velocity. It dead-reckons enemies through short cloak intervals and publishes a cleaned, predicted target list, so downstream aiming and evasion logic never keeps its own history registers.

## Interface
- NUM_SHIPS, 3, number of enemy ships tracked (one slot each)
- COAST_MAX, 4, cycles an enemy may stay cloaked before its track is dropped
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enemy_x_p[NUM_SHIPS], enemy_y_p[NUM_SHIPS]  in  signed 8 each  raw enemy positions; frozen by the environment while cloaked
- enemy_cloaked  in  NUM_SHIPS  enemy cloaked this cycle
- enemy_destroyed  in  NUM_SHIPS  enemy destroyed (sticky in the environment)
- trk_x[NUM_SHIPS], trk_y[NUM_SHIPS]  out  signed 8 each  target position (predicted next-cycle position when prediction is compiled in)
- trk_vx[NUM_SHIPS], trk_vy[NUM_SHIPS]  out  signed 5 each  estimated velocity per cycle
- trk_valid  out  NUM_SHIPS  track usable for aiming (state TRACK or COAST)
- trk_state[NUM_SHIPS]  out  3 each  slot state code
- trk_coast_cnt[NUM_SHIPS]  out  3 each  cycles spent coasting

## Operation
- Each slot has a registered position estimate pos, a velocity vel, a coast counter and a state.
- State codes: UNSEEN=0, ACQUIRE=1, TRACK=2, COAST=3, LOST=4, DEAD=5.
- Priority each cycle: destroyed > cloaked > visible.
- Any state with destroyed=1 goes to DEAD. DEAD is sticky until reset. In DEAD: vel=0, pos is held, valid=0.
- UNSEEN/LOST, visible: go to ACQUIRE; pos=input; vel=0.
- UNSEEN/LOST, cloaked: no change.
- ACQUIRE, visible: go to TRACK; vel=sat5(input−pos); pos=input.
- ACQUIRE, cloaked: go to LOST; vel=0.
- TRACK, visible: stay in TRACK; vel=sat5(input−pos); pos=input.
- TRACK, cloaked: go to COAST; coast_cnt=1; pos=sat8(pos+vel).
- COAST, cloaked and coast_cnt<COAST_MAX: stay in COAST; coast_cnt++; pos=sat8(pos+vel).
- COAST, cloaked and coast_cnt==COAST_MAX: go to LOST; vel=0; coast_cnt=0; pos is held.
- COAST, visible: go to ACQUIRE; pos=input; vel=0; coast_cnt=0. The frozen pre-cloak inputs are never used as a velocity baseline.
- Differences are computed at 9 bits. sat5 clamps to −16..15. sat8 clamps to −128..127; there is no wrap-around.
- trk_x = sat8(pos+vel), per axis. trk_valid = state∈{TRACK, COAST}.
- Slots are fully independent; simultaneous events across slots need no arbitration.

## Timing
- All outputs are registered. An input sampled at edge N appears on the outputs after edge N (usable in cycle N+1). Latency is 1 cycle.
- The first valid track appears 2 visible samples after UNSEEN: trk_valid rises in the cycle after the second sample edge.
- Reset, in any state including mid-coast: state=UNSEEN, pos=0, vel=0, coast_cnt=0. All outputs are 0; trk_valid=0; trk_state=0.
- destroyed asserted in the same cycle as a cloak or visibility transition still resolves to DEAD on that edge.
- A COAST track stays valid for exactly COAST_MAX cycles. trk_valid falls on the edge that enters LOST.

## Configuration
- Macro: TRACKER_PREDICT_EN.
- Defined: trk_x/trk_y = sat8(pos+vel) (lead one cycle), and COAST advances pos by vel each cycle.
- Undefined: trk_x/trk_y = pos, and COAST holds pos constant. vel is still computed and output. All state transitions and timing are unchanged.

## Structure
- Shared package tracker_pkg holds:
  - the track_state_e enum and its codes
  - POS_W=8 and VEL_W=5
  - sat5/sat8 functions
- Sub-module enemy_track_slot holds one slot (state machine, pos/vel/coast registers). The top level generates NUM_SHIPS instances and does only port fan-out.

## Test plan
- Reset then hold enemy 0 visible at (10,−5), then (13,−7): state goes UNSEEN→ACQUIRE→TRACK. vel=(3,−2). trk_x/trk_y=(16,−9) with prediction compiled in, (13,−7) without. trk_valid=1.
- From TRACK with vel=(3,−2) at (13,−7), cloak for 4 cycles: trk_state=3. With prediction compiled in, pos steps (16,−9),(19,−11),(22,−13),(25,−15). coast_cnt=1..4. On the 5th cloaked cycle: LOST, trk_valid=0, vel=0.
- Uncloak during COAST at (0,0): ACQUIRE with vel=0. The next sample at (1,1) gives TRACK with vel=(1,1).
- Saturation case: previous pos=−128, input=127. vel clamps to 15, and trk_x=sat8(127+15)=127.
- Assert destroyed together with cloaked in TRACK: DEAD on that edge, trk_valid=0. DEAD persists after destroyed drops. Reset returns the slot to UNSEEN with all outputs 0.
- Drive all 3 slots with different simultaneous events (track, coast, destroy): each slot matches its own expected sequence with no cross-slot interference.
